lut_neuron_stream: RTL

- Parametrised, pipelined successor to our fixed combinational neuron truth-table modules.
- Maps one packed input vector (FANIN fields of IN_BW bits) to an OUT_BW-bit activation through a runtime-writable table held in distributed RAM.
- Adds a valid/ready stream, configuration writes and a bulk-clear state machine, so one netlist serves retrained tables without re-synthesis.
- Sits between layer register stages in the generated network.

---
 rtl/lut_neuron_pkg.sv | 18 +
 rtl/lut_table_ram.sv | 55 +++++
 rtl/lut_neuron_stream.sv | 106 ++++++++++
 3 files changed

// File: rtl/lut_neuron_pkg.sv
// Shared types and size helpers for the streaming LUT neuron and the generator wrapper.
package lut_neuron_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    CLEAR = 2'd2
  } state_t;

  function automatic int calc_addr_w(input int fanin, input int in_bw);
    return fanin * in_bw;
  endfunction

  function automatic int calc_depth(input int fanin, input int in_bw);
    return 1 << (fanin * in_bw);
  endfunction

endpackage

// File: rtl/lut_table_ram.sv
// Distributed-RAM truth table: one registered read port, one write port shared by
// configuration writes and the bulk-clear sweep.
module lut_table_ram #(
  parameter int    ADDR_W    = 8,
  parameter int    OUT_BW    = 2,
  parameter string INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [OUT_BW-1:0] rd_data,
  input  logic              cfg_we,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [OUT_BW-1:0] cfg_data,
  input  logic              clr_en,
  input  logic [ADDR_W-1:0] clr_addr
);

  localparam int DEPTH = 1 << ADDR_W;

  (* ram_style = "distributed", rom_style = "distributed" *)
  logic [OUT_BW-1:0] mem [DEPTH];

  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [OUT_BW-1:0] wdata;

  // The clear sweep owns the write port whenever it runs.
  always_comb begin
    we    = cfg_we;
    waddr = cfg_addr;
    wdata = cfg_data;
    if (clr_en) begin
      we    = 1'b1;
      waddr = clr_addr;
      wdata = '0;
    end
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
  end

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read and write share an edge, so a same-address collision returns the old entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/lut_neuron_stream.sv
// Two-stage valid/ready LUT neuron: registered address, registered table read,
// runtime table writes and a drain-then-clear sequencer.
module lut_neuron_stream
  import lut_neuron_pkg::*;
#(
  parameter int    FANIN     = 4,
  parameter int    IN_BW     = 2,
  parameter int    OUT_BW    = 2,
  parameter string INIT_FILE = "",
  localparam int   ADDR_W    = calc_addr_w(FANIN, IN_BW),
  localparam int   DEPTH     = calc_depth(FANIN, IN_BW)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_BW-1:0] out_data,
  input  logic              cfg_we,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [OUT_BW-1:0] cfg_data,
  input  logic              cfg_clear,
  output logic              busy
);

  state_t            state;
  logic [ADDR_W-1:0] cnt;
  logic              busy_reg;
  logic              s1_valid;
  logic [ADDR_W-1:0] s1_addr;
  logic              out_valid_reg;
  logic              stall;
  logic              advance;
  logic              accept;

  assign stall     = out_valid_reg && !out_ready;
  assign advance   = !stall;
  assign in_ready  = advance && (state == IDLE);
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_reg;
  assign busy      = busy_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid      <= 1'b0;
      s1_addr       <= '0;
      out_valid_reg <= 1'b0;
    end else if (advance) begin
      s1_valid      <= accept;
      out_valid_reg <= s1_valid;
      if (accept) s1_addr <= in_data;
    end
  end

  // Stage 2 may still be stalled when CLEAR starts; its word is already captured.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      busy_reg <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cfg_clear) begin
            state    <= DRAIN;
            busy_reg <= 1'b1;
          end
        end
        DRAIN: begin
          if (!s1_valid) state <= CLEAR;
        end
        CLEAR: begin
          cnt <= cnt + 1'b1;
          if (cnt == ADDR_W'(DEPTH - 1)) begin
            state    <= IDLE;
            busy_reg <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          busy_reg <= 1'b0;
        end
      endcase
    end
  end

  lut_table_ram #(
    .ADDR_W   (ADDR_W),
    .OUT_BW   (OUT_BW),
    .INIT_FILE(INIT_FILE)
  ) u_table (
    .clk     (clk),
    .rst     (rst),
    .rd_en   (advance),
    .rd_addr (s1_addr),
    .rd_data (out_data),
    .cfg_we  (cfg_we && (state == IDLE)),
    .cfg_addr(cfg_addr),
    .cfg_data(cfg_data),
    .clr_en  (state == CLEAR),
    .clr_addr(cnt)
  );

endmodule
